// File: rtl/sc_rx_port_dispatcher_if.sv
// SIE receive-port bundle plus the two client handshakes (getPacket, rxMonitor).
// slave = dispatcher view, master = driver/observer view.
interface sc_rx_port_dispatcher_if;
  logic [7:0] SCRxPortData;
  logic [7:0] SCRxPortCntl;
  logic       SCRxPortRdy;
  logic       getPacketReq;
  logic       getPacketAck;
  logic       rxMonReq;
  logic       rxMonAck;
  logic       getPacketGnt;
  logic       rxMonGnt;
  logic [7:0] getPacketData;
  logic [7:0] getPacketCntl;
  logic       getPacketValid;
  logic [7:0] rxMonData;
  logic [7:0] rxMonCntl;
  logic       rxMonValid;
  logic       rxOverflow;
  logic [7:0] rxDropCount;

  modport slave (
    input  SCRxPortData, SCRxPortCntl, SCRxPortRdy,
    input  getPacketReq, getPacketAck, rxMonReq, rxMonAck,
    output getPacketGnt, rxMonGnt,
    output getPacketData, getPacketCntl, getPacketValid,
    output rxMonData, rxMonCntl, rxMonValid,
    output rxOverflow, rxDropCount
  );

  modport master (
    output SCRxPortData, SCRxPortCntl, SCRxPortRdy,
    output getPacketReq, getPacketAck, rxMonReq, rxMonAck,
    input  getPacketGnt, rxMonGnt,
    input  getPacketData, getPacketCntl, getPacketValid,
    input  rxMonData, rxMonCntl, rxMonValid,
    input  rxOverflow, rxDropCount
  );
endinterface

// File: rtl/sc_rx_port_dispatcher.sv
// RX port dispatcher: buffers SIE bytes in a small FIFO and serves one granted owner (getPacket first).
// Byte visible one cycle after its strobe; strobes with no owner or a full FIFO are dropped and counted.
module sc_rx_port_dispatcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input logic                   clk,
  input logic                   rst,
  sc_rx_port_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {START, IDLE, GP_OWN, MON_OWN} state_e;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  state_e           state_q, state_d;
  logic             gp_gnt_q, gp_gnt_d;
  logic             mon_gnt_q, mon_gnt_d;
  logic             flush;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic             ovf_q;
  logic [7:0]       drop_cnt_q;

  logic        empty, full, owner_req;
  logic        gp_vld, mon_vld, push, pop, drop;
  logic [15:0] head;

  always_comb begin
    state_d   = state_q;
    gp_gnt_d  = gp_gnt_q;
    mon_gnt_d = mon_gnt_q;
    flush     = 1'b0;
    case (state_q)
      START: state_d = IDLE;
      IDLE: begin
        if (bus.getPacketReq) begin
          state_d  = GP_OWN;
          gp_gnt_d = 1'b1;
        end else if (bus.rxMonReq) begin
          state_d   = MON_OWN;
          mon_gnt_d = 1'b1;
        end
      end
      GP_OWN: begin
        if (!bus.getPacketReq) begin
          state_d  = IDLE;
          gp_gnt_d = 1'b0;
          flush    = 1'b1;
        end
      end
      MON_OWN: begin
        if (!bus.rxMonReq) begin
          state_d   = IDLE;
          mon_gnt_d = 1'b0;
          flush     = 1'b1;
        end
      end
      default: begin
        state_d   = START;
        gp_gnt_d  = 1'b0;
        mon_gnt_d = 1'b0;
      end
    endcase
  end

  // Release cycle has the owner's request low, so it never pushes: the strobe is dropped.
  assign owner_req = ((state_q == GP_OWN) && bus.getPacketReq) ||
                     ((state_q == MON_OWN) && bus.rxMonReq);
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign gp_vld    = gp_gnt_q & ~empty;
  assign mon_vld   = mon_gnt_q & ~empty;
  assign pop       = (gp_vld & bus.getPacketAck) | (mon_vld & bus.rxMonAck);
  assign push      = bus.SCRxPortRdy & owner_req & (~full | pop);
  assign drop      = bus.SCRxPortRdy & ~push;
  assign head      = empty ? 16'h0000 : mem_q[rd_ptr_q];

  assign bus.getPacketGnt   = gp_gnt_q;
  assign bus.rxMonGnt       = mon_gnt_q;
  assign bus.getPacketValid = gp_vld;
  assign bus.rxMonValid     = mon_vld;
  assign bus.getPacketData  = gp_gnt_q  ? head[7:0]  : 8'h00;
  assign bus.getPacketCntl  = gp_gnt_q  ? head[15:8] : 8'h00;
  assign bus.rxMonData      = mon_gnt_q ? head[7:0]  : 8'h00;
  assign bus.rxMonCntl      = mon_gnt_q ? head[15:8] : 8'h00;
  assign bus.rxOverflow     = ovf_q;
  assign bus.rxDropCount    = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= START;
      gp_gnt_q   <= 1'b0;
      mon_gnt_q  <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      gp_gnt_q  <= gp_gnt_d;
      mon_gnt_q <= mon_gnt_d;
      ovf_q     <= drop;
      if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'h01;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + (PTR_W+1)'(1);
          2'b01:   count_q <= count_q - (PTR_W+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.SCRxPortCntl, bus.SCRxPortData};
  end

endmodule

// File: tb/tb_sc_rx_port_dispatcher.sv
// Directed bench for sc_rx_port_dispatcher: arbitration, FIFO ordering, drops and reset.
module tb_sc_rx_port_dispatcher;
  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  sc_rx_port_dispatcher_if bus ();

  sc_rx_port_dispatcher #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d, input logic [7:0] c);
    bus.SCRxPortRdy  = 1'b1;
    bus.SCRxPortData = d;
    bus.SCRxPortCntl = c;
  endtask

  initial begin
    rst = 1'b1;
    bus.SCRxPortData = 8'h00;
    bus.SCRxPortCntl = 8'h00;
    bus.SCRxPortRdy  = 1'b0;
    bus.getPacketReq = 1'b0;
    bus.getPacketAck = 1'b0;
    bus.rxMonReq     = 1'b0;
    bus.rxMonAck     = 1'b0;
    tick();
    tick();
    check("rst_gp_gnt", 32'(bus.getPacketGnt), 32'd0);
    check("rst_mon_gnt", 32'(bus.rxMonGnt), 32'd0);
    check("rst_gp_vld", 32'(bus.getPacketValid), 32'd0);
    check("rst_mon_vld", 32'(bus.rxMonValid), 32'd0);
    check("rst_gp_data", 32'(bus.getPacketData), 32'h00);
    check("rst_ovf", 32'(bus.rxOverflow), 32'd0);
    check("rst_dropcnt", 32'(bus.rxDropCount), 32'd0);

    // Grant latency: START, IDLE, then GP_OWN
    rst = 1'b0;
    bus.getPacketReq = 1'b1;
    tick();
    check("gp_gnt_start", 32'(bus.getPacketGnt), 32'd0);
    tick();
    check("gp_gnt_on", 32'(bus.getPacketGnt), 32'd1);
    check("gp_mon_gnt_off", 32'(bus.rxMonGnt), 32'd0);
    check("gp_vld_empty", 32'(bus.getPacketValid), 32'd0);

    // Two bytes, acked whenever valid
    strobe(8'hA5, 8'h01);
    tick();
    check("gp_vld_1", 32'(bus.getPacketValid), 32'd1);
    check("gp_data_1", 32'(bus.getPacketData), 32'hA5);
    check("gp_cntl_1", 32'(bus.getPacketCntl), 32'h01);
    strobe(8'h3C, 8'h02);
    bus.getPacketAck = 1'b1;
    tick();
    check("gp_vld_2", 32'(bus.getPacketValid), 32'd1);
    check("gp_data_2", 32'(bus.getPacketData), 32'h3C);
    check("gp_cntl_2", 32'(bus.getPacketCntl), 32'h02);
    bus.SCRxPortRdy = 1'b0;
    tick();
    check("gp_vld_done", 32'(bus.getPacketValid), 32'd0);
    check("gp_data_empty", 32'(bus.getPacketData), 32'h00);
    check("gp_dropcnt", 32'(bus.rxDropCount), 32'd0);
    bus.getPacketAck = 1'b0;

    // Release, then both request together
    bus.getPacketReq = 1'b0;
    tick();
    check("rel_gp_gnt", 32'(bus.getPacketGnt), 32'd0);
    bus.getPacketReq = 1'b1;
    bus.rxMonReq     = 1'b1;
    tick();
    check("both_gp_gnt", 32'(bus.getPacketGnt), 32'd1);
    check("both_mon_gnt", 32'(bus.rxMonGnt), 32'd0);
    bus.getPacketReq = 1'b0;
    tick();
    check("gap_gp_gnt", 32'(bus.getPacketGnt), 32'd0);
    check("gap_mon_gnt", 32'(bus.rxMonGnt), 32'd0);
    tick();
    check("mon_gnt_on", 32'(bus.rxMonGnt), 32'd1);
    check("mon_gp_gnt_off", 32'(bus.getPacketGnt), 32'd0);

    // Five strobes with no ack: fifth overflows
    for (int i = 0; i < 5; i++) begin
      strobe(8'h10 + 8'(i), 8'h80 + 8'(i));
      tick();
      if (i == 3) check("fill_no_ovf", 32'(bus.rxOverflow), 32'd0);
    end
    check("full_ovf", 32'(bus.rxOverflow), 32'd1);
    check("full_dropcnt", 32'(bus.rxDropCount), 32'd1);
    bus.SCRxPortRdy = 1'b0;
    tick();
    check("ovf_one_pulse", 32'(bus.rxOverflow), 32'd0);
    check("nonowner_vld", 32'(bus.getPacketValid), 32'd0);
    check("nonowner_data", 32'(bus.getPacketData), 32'h00);
    bus.rxMonAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_vld", 32'(bus.rxMonValid), 32'd1);
      check("drain_data", 32'(bus.rxMonData), 32'h10 + 32'(i));
      check("drain_cntl", 32'(bus.rxMonCntl), 32'h80 + 32'(i));
      tick();
    end
    check("drain_empty", 32'(bus.rxMonValid), 32'd0);

    // Full FIFO with simultaneous strobe and ack, then streaming across pointer wrap
    bus.rxMonAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      strobe(8'h20 + 8'(i), 8'h00);
      tick();
    end
    bus.rxMonAck = 1'b1;
    strobe(8'h24, 8'h00);
    tick();
    check("fullpop_ovf", 32'(bus.rxOverflow), 32'd0);
    check("fullpop_dropcnt", 32'(bus.rxDropCount), 32'd1);
    check("fullpop_head", 32'(bus.rxMonData), 32'h21);
    for (int i = 0; i < 10; i++) begin
      strobe(8'h25 + 8'(i), 8'h00);
      tick();
      check("stream_head", 32'(bus.rxMonData), 32'h22 + 32'(i));
      check("stream_ovf", 32'(bus.rxOverflow), 32'd0);
    end
    bus.SCRxPortRdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tail_data", 32'(bus.rxMonData), 32'h2B + 32'(i));
      tick();
    end
    check("tail_empty", 32'(bus.rxMonValid), 32'd0);
    check("stream_dropcnt", 32'(bus.rxDropCount), 32'd1);
    bus.rxMonAck = 1'b0;
    bus.rxMonReq = 1'b0;
    tick();
    check("mon_rel", 32'(bus.rxMonGnt), 32'd0);

    // Fresh reset; strobes in START and IDLE with nobody requesting are dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe(8'h50 + 8'(i), 8'h00);
      tick();
      check("noown_ovf", 32'(bus.rxOverflow), 32'd1);
    end
    check("noown_dropcnt", 32'(bus.rxDropCount), 32'd3);
    for (int i = 0; i < 257; i++) tick();
    check("sat_dropcnt", 32'(bus.rxDropCount), 32'hFF);
    bus.SCRxPortRdy = 1'b0;

    // Reset mid-transfer with two bytes buffered
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.getPacketReq = 1'b1;
    tick();
    tick();
    check("mid_gnt", 32'(bus.getPacketGnt), 32'd1);
    strobe(8'h61, 8'h00);
    tick();
    strobe(8'h62, 8'h00);
    tick();
    bus.SCRxPortRdy = 1'b0;
    check("mid_vld", 32'(bus.getPacketValid), 32'd1);
    check("mid_head", 32'(bus.getPacketData), 32'h61);
    rst = 1'b1;
    bus.getPacketAck = 1'b1;
    strobe(8'h63, 8'h00);
    tick();
    check("midrst_gnt", 32'(bus.getPacketGnt), 32'd0);
    check("midrst_vld", 32'(bus.getPacketValid), 32'd0);
    check("midrst_data", 32'(bus.getPacketData), 32'h00);
    check("midrst_dropcnt", 32'(bus.rxDropCount), 32'd0);
    rst = 1'b0;
    bus.SCRxPortRdy  = 1'b0;
    bus.getPacketAck = 1'b0;
    tick();
    tick();
    check("post_gnt", 32'(bus.getPacketGnt), 32'd1);
    check("post_vld", 32'(bus.getPacketValid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sc_rx_port_dispatcher.md
Name: sc_rx_port_dispatcher

Overview:
Receive-side counterpart of the slave controller's TX port arbiter. It accepts the byte stream from the SIE receive port (data, control and a one-cycle ready strobe) and buffers it in a small FIFO. Two clients can request the port: getPacket and an rxMonitor/direct-control client. The block grants exactly one owner at a time, with fixed priority to getPacket, and hands bytes to that owner over a valid/ack handshake. Bytes that cannot be delivered are dropped and counted.

Parameters:
FIFO_DEPTH, 4, number of byte entries in the receive buffer (power of two, 2..16)
PTR_W, 2, log2(FIFO_DEPTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
SCRxPortData  in  8  received byte
SCRxPortCntl  in  8  control/status tag accompanying the byte
SCRxPortRdy  in  1  one-cycle strobe: Data/Cntl valid this cycle
getPacketReq  in  1  getPacket requests ownership, held for the whole transfer
getPacketAck  in  1  getPacket consumes the head byte this cycle
rxMonReq  in  1  monitor client requests ownership
rxMonAck  in  1  monitor consumes the head byte this cycle
getPacketGnt  out  1  registered grant to getPacket
rxMonGnt  out  1  registered grant to monitor
getPacketData/getPacketCntl  out  8/8  FIFO head, muxed to getPacket
getPacketValid  out  1  head valid for getPacket
rxMonData/rxMonCntl  out  8/8  FIFO head, muxed to monitor
rxMonValid  out  1  head valid for monitor
rxOverflow  out  1  one-cycle pulse when an incoming byte is dropped
rxDropCount  out  8  saturating count of dropped bytes

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=START, both Gnt=0, FIFO empty (count=0, pointers=0), both Valid=0, Data/Cntl outputs=0x00, rxOverflow=0, rxDropCount=0.
- Reset mid-operation: on the next edge the FIFO is discarded and the block returns to START regardless of request or ack inputs.
- State machine:
  - START -> IDLE unconditionally after one cycle.
  - IDLE:
    - getPacketReq -> GP_OWN, next getPacketGnt=1.
    - Otherwise rxMonReq -> MON_OWN, next rxMonGnt=1.
    - If both requests are high, getPacket wins.
  - GP_OWN: when ~getPacketReq -> IDLE, getPacketGnt=0, FIFO flushed on the same edge.
  - MON_OWN: when ~rxMonReq -> IDLE, rxMonGnt=0, FIFO flushed on the same edge.
  - No preemption: a request from the other client is ignored until return to IDLE. Minimum one IDLE cycle between owners.
- Grants are registered: they assert the cycle after the request is sampled in IDLE, and deassert the cycle after the request drops.
- Push rule: push occurs when SCRxPortRdy=1, the state is GP_OWN or MON_OWN, the owner's request is still high, and (count<FIFO_DEPTH or a pop occurs this cycle).
- Drop rule:
  - Any SCRxPortRdy that does not push is dropped: no owner, START, the release cycle, or full without pop.
  - A drop produces rxOverflow=1 on the next cycle (registered) and increments rxDropCount, saturating at 0xFF.
- Output path:
  - Head Data/Cntl are combinational from the FIFO read pointer and zero when empty.
  - Valid = owner grant & ~empty. The non-owner sees Valid=0 and Data/Cntl=0x00.
  - Pop occurs when the owner's Valid & Ack are high. Ack without Valid is ignored.
  - Latency: a byte pushed at edge N is visible as Valid after edge N (next cycle).
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- Flush on release: pointers and count are cleared. The pending head is not delivered.

Test Plan:
- Reset, then getPacketReq=1 -> getPacketGnt=1 two cycles after rst falls (START, IDLE, GP_OWN); rxMonGnt stays 0; all Valid=0.
- In GP_OWN, strobe bytes 0xA5/cntl 0x01, 0x3C/0x02 on consecutive cycles, with Ack=1 whenever Valid -> getPacketData shows 0xA5 then 0x3C; getPacketValid is high for exactly 2 cycles; rxDropCount=0.
- Both requests raised in the same cycle -> getPacketGnt=1 and rxMonGnt=0. Drop getPacketReq -> one IDLE cycle, then rxMonGnt=1.
- Owner holds Ack=0 and 5 bytes are strobed with FIFO_DEPTH=4 -> first 4 buffered, 5th dropped; rxOverflow pulses once; rxDropCount=1. Then Ack=1 -> the 4 bytes are delivered in order.
- FIFO full with a strobe and Ack in the same cycle -> no drop; count stays 4; order preserved across pointer wrap (push 10 bytes with continuous Ack, all received in order).
- Strobe 3 bytes with no requester -> rxDropCount=3. Assert rst mid-transfer with 2 bytes buffered -> FIFO empty and Gnt=0 on the next cycle; rxDropCount=0.
